regfile_port_ctrl: RTL and testbench
====================================

Name: regfile_port_ctrl

Overview:
- Initiator side of the register-file access interface. Sits between the decode stage and the 32x32 register file (x0 hard-wired to 0).
- Accepts operand-fetch requests and drives the two read ports. Registers the fetched operands toward execute.
- Drives the single write port from the writeback stage.
- Keeps a 32-entry busy scoreboard to stall RAW/WAW hazards, with optional same-cycle writeback bypass.

Parameters:
- BYPASS_EN, 1: 1 = forward writeback data into a same-cycle operand fetch; 0 = stall until the cycle after writeback.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  operand-fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rs1  in  5  source 1 index
- req_rs2  in  5  source 2 index
- req_use_rs1  in  1  rs1 is read
- req_use_rs2  in  1  rs2 is read
- req_rd  in  5  destination index
- req_has_rd  in  1  instruction will write rd
- op_valid  out  1  operand slot full
- op_ready  in  1  execute consumes slot
- op_a  out  32  operand A
- op_b  out  32  operand B
- wb_valid  in  1  writeback valid; always accepted, no ready
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- rf_rd0_en  out  1  regfile read port 0 enable
- rf_rd0_addr  out  5  regfile read port 0 address
- rf_rd0_data  in  32  regfile read port 0 data, combinational
- rf_rd1_en  out  1  regfile read port 1 enable
- rf_rd1_addr  out  5  regfile read port 1 address
- rf_rd1_data  in  32  regfile read port 1 data, combinational
- rf_wr_en  out  1  regfile write enable, committed at clk edge
- rf_wr_addr  out  5  regfile write address
- rf_wr_data  out  32  regfile write data
- sb_busy  out  32  scoreboard, bit i = write to xi pending
- err_wb_unexp  out  1  sticky: writeback to a register that is not busy

Behaviour:
- Reset (async, reset_n=0): sb_busy=0, op_valid=0, op_a=op_b=0, err_wb_unexp=0. All combinational enables are 0 while req_valid=0 and wb_valid=0.
- Read port outputs:
  - rf_rd0_addr=req_rs1 and rf_rd1_addr=req_rs2, always driven.
  - rf_rd0_en=req_valid&&req_use_rs1; rf_rd1_en=req_valid&&req_use_rs2.
- Write port outputs: rf_wr_en=wb_valid&&(wb_rd!=0); rf_wr_addr=wb_rd; rf_wr_data=wb_data.
- Slot state machine (EMPTY/FULL, mirrored by op_valid):
  - EMPTY -> FULL on accept.
  - FULL stays FULL on accept&&op_ready (back-to-back, 1 request per cycle throughput).
  - FULL -> EMPTY on op_ready without accept.
  - FULL holds op_a/op_b stable while op_ready=0.
- clr_i = wb_valid&&wb_rd==i. x0 is never busy.
- Hazard rules:
  - Source hazard: src used && src!=0 && sb_busy[src] && !(BYPASS_EN && clr_src).
  - Dest hazard: req_has_rd && req_rd!=0 && sb_busy[req_rd] && !clr_rd. A WAW release on the same-cycle writeback is allowed regardless of BYPASS_EN.
- req_ready = (!op_valid || op_ready) && no hazard. It is combinational and may depend on wb_* inputs.
- Operand capture on accept, latency 1 (op_valid rises the cycle after accept):
  - op_a = 0 if !use_rs1 or rs1==0.
  - Else op_a = wb_data if BYPASS_EN && clr_rs1.
  - Else op_a = rf_rd0_data.
  - op_b is computed the same way from rs2 / rf_rd1_data.
- Scoreboard update per cycle:
  - busy[i] <= (busy[i] && !clr_i) || set_i, where set_i = accept && req_has_rd && req_rd==i && i!=0.
  - Set wins over clear on the same index.
- Writeback to x0: no regfile write, no error.
- Writeback to a register with busy=0 (and not x0): the regfile write still occurs and err_wb_unexp sets. err_wb_unexp stays set until reset.
- Reset mid-operation: the slot and scoreboard are cleared immediately. In-flight writebacks arriving later raise err_wb_unexp.

Test Plan:
- Write-then-read: reset; wb x5=0xDEADBEEF; next cycle req rs1=5, rs2=0 -> one cycle later op_valid=1, op_a=0xDEADBEEF, op_b=0.
- RAW stall with bypass: accept req rd=7 (sb_busy[7]=1); req rs1=7 held 3 cycles -> req_ready=0 for those cycles. On the cycle wb x7=0x12345678 is presented: req_ready=1 and op_a=0x12345678 next cycle; sb_busy[7]=0.
- RAW stall with BYPASS_EN=0: same stimulus -> accept occurs one cycle after the writeback; op_a=0x12345678 comes from rf_rd0_data.
- Backpressure: op_ready=0 with slot full and a new req -> req_ready=0; op_a/op_b unchanged for 4 cycles. Release op_ready -> new request accepted the same cycle, throughput 1 per cycle.
- Set/clear collision: wb x9 and accept req rd=9 in the same cycle -> rf_wr_en=1, sb_busy[9]=1 afterwards, err_wb_unexp=0.
- Error and reset: wb x3 with sb_busy[3]=0 -> write performed, err_wb_unexp=1. Assert reset_n=0 mid-stream -> op_valid, sb_busy and err_wb_unexp all 0 asynchronously.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Register-file access controller: operand fetch, writeback port and busy scoreboard.
// Stalls RAW/WAW hazards; BYPASS_EN forwards same-cycle writeback data into the fetch.
module regfile_port_ctrl #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic        req_use_rs1,
  input  logic        req_use_rs2,
  input  logic [4:0]  req_rd,
  input  logic        req_has_rd,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        rf_rd0_en,
  output logic [4:0]  rf_rd0_addr,
  input  logic [31:0] rf_rd0_data,
  output logic        rf_rd1_en,
  output logic [4:0]  rf_rd1_addr,
  input  logic [31:0] rf_rd1_data,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic [31:0] sb_busy,
  output logic        err_wb_unexp
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic [XLEN-1:0]   w_op_a_nxt;
  logic [XLEN-1:0]   w_op_b_nxt;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_clr;
  logic [NREG-1:0]   w_set;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_err;
  logic              w_err_set;
  logic              w_haz_rs1;
  logic              w_haz_rs2;
  logic              w_haz_rd;
  logic              w_accept;

  // Operand select: x0/unused reads as zero, then writeback bypass, then regfile.
  function automatic logic [XLEN-1:0] sel_opnd(
    input logic            use_src,
    input logic [AW-1:0]   idx,
    input logic [XLEN-1:0] rf_data,
    input logic            byp_hit,
    input logic [XLEN-1:0] byp_data
  );
    if (!use_src || idx == '0) sel_opnd = '0;
    else if (BYPASS_EN && byp_hit) sel_opnd = byp_data;
    else sel_opnd = rf_data;
  endfunction

  assign rf_rd0_addr = req_rs1;
  assign rf_rd1_addr = req_rs2;
  assign rf_rd0_en   = req_valid && req_use_rs1;
  assign rf_rd1_en   = req_valid && req_use_rs2;

  assign rf_wr_en    = wb_valid && (wb_rd != '0);
  assign rf_wr_addr  = wb_rd;
  assign rf_wr_data  = wb_data;

  assign w_clr = wb_valid ? (NREG'(1) << wb_rd) : '0;

  // A same-cycle writeback always releases WAW; it releases RAW only with bypass.
  always_comb begin
    w_haz_rs1 = req_use_rs1 && (req_rs1 != '0) && r_busy[req_rs1] &&
                !(BYPASS_EN && w_clr[req_rs1]);
    w_haz_rs2 = req_use_rs2 && (req_rs2 != '0) && r_busy[req_rs2] &&
                !(BYPASS_EN && w_clr[req_rs2]);
    w_haz_rd  = req_has_rd && (req_rd != '0) && r_busy[req_rd] && !w_clr[req_rd];
  end

  assign req_ready = ((r_state == S_EMPTY) || op_ready) &&
                     !(w_haz_rs1 || w_haz_rs2 || w_haz_rd);
  assign w_accept  = req_valid && req_ready;

  // Set is OR'ed after the clear so an accept wins over a writeback to the same index.
  assign w_set      = (w_accept && req_has_rd && (req_rd != '0)) ? (NREG'(1) << req_rd) : '0;
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~NREG'(1);
  assign w_err_set  = wb_valid && (wb_rd != '0) && !r_busy[wb_rd];

  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    if (r_state == S_EMPTY) begin
      if (w_accept) w_state_nxt = S_FULL;
    end else begin
      if (!w_accept && op_ready) w_state_nxt = S_EMPTY;
    end
    if (w_accept) begin
      w_op_a_nxt = sel_opnd(req_use_rs1, req_rs1, rf_rd0_data, w_clr[req_rs1], wb_data);
      w_op_b_nxt = sel_opnd(req_use_rs2, req_rs2, rf_rd1_data, w_clr[req_rs2], wb_data);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_busy  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= r_err || w_err_set;
    end
  end

  assign op_valid     = (r_state == S_FULL);
  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign sb_busy      = r_busy;
  assign err_wb_unexp = r_err;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl: bypass and no-bypass instances, each with a regfile model.
module tb_regfile_port_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, b_req_valid;
  logic        req_ready, b_req_ready;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        req_use_rs1, req_use_rs2, req_has_rd;
  logic        op_valid, b_op_valid;
  logic        op_ready;
  logic [31:0] op_a, op_b, b_op_a, b_op_b;
  logic        wb_valid, b_wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_rd0_en, rf_rd1_en, b_rf_rd0_en, b_rf_rd1_en;
  logic [4:0]  rf_rd0_addr, rf_rd1_addr, b_rf_rd0_addr, b_rf_rd1_addr;
  logic [31:0] rf_rd0_data, rf_rd1_data, b_rf_rd0_data, b_rf_rd1_data;
  logic        rf_wr_en, b_rf_wr_en;
  logic [4:0]  rf_wr_addr, b_rf_wr_addr;
  logic [31:0] rf_wr_data, b_rf_wr_data;
  logic [31:0] sb_busy, b_sb_busy;
  logic        err_wb_unexp, b_err_wb_unexp;

  logic [31:0] rfa [32] = '{default: '0};
  logic [31:0] rfb [32] = '{default: '0};
  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(.BYPASS_EN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs1(req_use_rs1), .req_use_rs2(req_use_rs2),
    .req_rd(req_rd), .req_has_rd(req_has_rd),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rd0_en(rf_rd0_en), .rf_rd0_addr(rf_rd0_addr), .rf_rd0_data(rf_rd0_data),
    .rf_rd1_en(rf_rd1_en), .rf_rd1_addr(rf_rd1_addr), .rf_rd1_data(rf_rd1_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .sb_busy(sb_busy), .err_wb_unexp(err_wb_unexp)
  );

  regfile_port_ctrl #(.BYPASS_EN(1'b0)) u_dut_nb (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_use_rs1(req_use_rs1), .req_use_rs2(req_use_rs2),
    .req_rd(req_rd), .req_has_rd(req_has_rd),
    .op_valid(b_op_valid), .op_ready(op_ready), .op_a(b_op_a), .op_b(b_op_b),
    .wb_valid(b_wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rd0_en(b_rf_rd0_en), .rf_rd0_addr(b_rf_rd0_addr), .rf_rd0_data(b_rf_rd0_data),
    .rf_rd1_en(b_rf_rd1_en), .rf_rd1_addr(b_rf_rd1_addr), .rf_rd1_data(b_rf_rd1_data),
    .rf_wr_en(b_rf_wr_en), .rf_wr_addr(b_rf_wr_addr), .rf_wr_data(b_rf_wr_data),
    .sb_busy(b_sb_busy), .err_wb_unexp(b_err_wb_unexp)
  );

  // Register file models with combinational read and clocked write
  assign rf_rd0_data   = rfa[rf_rd0_addr];
  assign rf_rd1_data   = rfa[rf_rd1_addr];
  assign b_rf_rd0_data = rfb[b_rf_rd0_addr];
  assign b_rf_rd1_data = rfb[b_rf_rd1_addr];

  always @(posedge clk) begin
    if (rf_wr_en) rfa[rf_wr_addr] <= rf_wr_data;
    if (b_rf_wr_en) rfb[b_rf_wr_addr] <= b_rf_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] b);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed output expected none queued", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(v), 32'd1);
      chk({tag, "_a"}, a, e.a);
      chk({tag, "_b"}, b, e.b);
    end
  endtask

  task automatic drv_req(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic hrd);
    req_valid = v; req_rs1 = rs1; req_use_rs1 = u1;
    req_rs2 = rs2; req_use_rs2 = u2; req_rd = rd; req_has_rd = hrd;
  endtask

  task automatic drv_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    reset_n = 1'b0; op_ready = 1'b1; b_req_valid = 1'b0; b_wb_valid = 1'b0;
    drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drv_wb(1'b0, 5'd0, 32'h0);

    // Reset state
    @(negedge clk); #1;
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_busy", sb_busy, 32'h0);
    chk("rst_err", 32'(err_wb_unexp), 32'd0);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_en", {29'd0, rf_rd0_en, rf_rd1_en, rf_wr_en}, 32'd0);
    reset_n = 1'b1;

    // Write-then-read
    @(negedge clk); drv_wb(1'b1, 5'd5, 32'hDEADBEEF); #1;
    chk("t1_wr_en", 32'(rf_wr_en), 32'd1);
    chk("t1_wr_addr", 32'(rf_wr_addr), 32'd5);
    @(negedge clk); drv_wb(1'b0, 5'd0, 32'h0);
    drv_req(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0); #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    chk("t1_rd_en", {30'd0, rf_rd0_en, rf_rd1_en}, 32'd3);
    exp_q.push_back('{a: 32'hDEADBEEF, b: 32'h0});
    @(negedge clk); drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t1_op", op_valid, op_a, op_b);
    chk("t1_err_unexp", 32'(err_wb_unexp), 32'd1);
    reset_n = 1'b0; #1;
    chk("t1_err_rst", 32'(err_wb_unexp), 32'd0);
    @(negedge clk); reset_n = 1'b1;

    // RAW stall with bypass
    @(negedge clk); drv_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
    chk("t2_ready_rd", 32'(req_ready), 32'd1);
    exp_q.push_back('{a: 32'h0, b: 32'h0});
    @(negedge clk); drv_req(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t2_op0", op_valid, op_a, op_b);
    chk("t2_busy7", sb_busy, 32'h80);
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
    end
    drv_wb(1'b1, 5'd7, 32'h12345678); #1;
    chk("t2_byp_ready", 32'(req_ready), 32'd1);
    exp_q.push_back('{a: 32'h12345678, b: 32'h0});
    @(negedge clk); drv_wb(1'b0, 5'd0, 32'h0);
    drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t2_op1", op_valid, op_a, op_b);
    chk("t2_busy_clr", sb_busy, 32'h0);
    chk("t2_err", 32'(err_wb_unexp), 32'd0);

    // RAW stall without bypass: accept only after the writeback lands
    @(negedge clk); b_req_valid = 1'b1;
    drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1); #1;
    chk("t3_ready_rd", 32'(b_req_ready), 32'd1);
    exp_q.push_back('{a: 32'h0, b: 32'h0});
    @(negedge clk); drv_req(1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t3_op0", b_op_valid, b_op_a, b_op_b);
    chk("t3_stall", 32'(b_req_ready), 32'd0);
    @(negedge clk); b_wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12345678; #1;
    chk("t3_wb_stall", 32'(b_req_ready), 32'd0);
    @(negedge clk); b_wb_valid = 1'b0; wb_data = 32'h0; #1;
    chk("t3_ready_after", 32'(b_req_ready), 32'd1);
    chk("t3_busy_clr", b_sb_busy, 32'h0);
    exp_q.push_back('{a: 32'h12345678, b: 32'h0});
    @(negedge clk); b_req_valid = 1'b0; #1;
    pop_chk("t3_op1", b_op_valid, b_op_a, b_op_b);

    // Backpressure, then back-to-back throughput
    @(negedge clk); op_ready = 1'b0;
    drv_req(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0); #1;
    chk("t4_ready0", 32'(req_ready), 32'd1);
    exp_q.push_back('{a: 32'hDEADBEEF, b: 32'h12345678});
    @(negedge clk); drv_req(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_bp_ready", 32'(req_ready), 32'd0);
      chk("t4_hold_a", op_a, 32'hDEADBEEF);
      chk("t4_hold_b", op_b, 32'h12345678);
      @(negedge clk);
    end
    op_ready = 1'b1; #1;
    chk("t4_release", 32'(req_ready), 32'd1);
    pop_chk("t4_op0", op_valid, op_a, op_b);
    exp_q.push_back('{a: 32'h12345678, b: 32'hDEADBEEF});
    @(negedge clk); drv_req(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0); #1;
    chk("t4_b2b_ready", 32'(req_ready), 32'd1);
    pop_chk("t4_op1", op_valid, op_a, op_b);
    exp_q.push_back('{a: 32'h0, b: 32'hDEADBEEF});
    @(negedge clk); drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t4_op2", op_valid, op_a, op_b);

    // Set/clear collision on x9
    @(negedge clk); drv_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); #1;
    exp_q.push_back('{a: 32'h0, b: 32'h0});
    @(negedge clk); drv_wb(1'b1, 5'd9, 32'h99); #1;
    pop_chk("t5_op0", op_valid, op_a, op_b);
    chk("t5_waw_ready", 32'(req_ready), 32'd1);
    chk("t5_wr_en", 32'(rf_wr_en), 32'd1);
    exp_q.push_back('{a: 32'h0, b: 32'h0});
    @(negedge clk); drv_wb(1'b0, 5'd0, 32'h0);
    drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    pop_chk("t5_op1", op_valid, op_a, op_b);
    chk("t5_busy9", sb_busy, 32'h200);
    chk("t5_err", 32'(err_wb_unexp), 32'd0);

    // x0 writeback, unexpected writeback, mid-stream reset, late writeback
    @(negedge clk); drv_wb(1'b1, 5'd0, 32'hAA); #1;
    chk("t6_x0_wr_en", 32'(rf_wr_en), 32'd0);
    @(negedge clk); drv_wb(1'b1, 5'd3, 32'h33); #1;
    chk("t6_x3_wr_en", 32'(rf_wr_en), 32'd1);
    chk("t6_x0_noerr", 32'(err_wb_unexp), 32'd0);
    @(negedge clk); drv_wb(1'b0, 5'd0, 32'h0); op_ready = 1'b0;
    drv_req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1); #1;
    chk("t6_err_set", 32'(err_wb_unexp), 32'd1);
    chk("t6_ready", 32'(req_ready), 32'd1);
    @(negedge clk); drv_req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0); #1;
    chk("t6_full", 32'(op_valid), 32'd1);
    chk("t6_busy", sb_busy, 32'h0000_0A00);
    reset_n = 1'b0; #1;
    chk("t6_rst_valid", 32'(op_valid), 32'd0);
    chk("t6_rst_busy", sb_busy, 32'h0);
    chk("t6_rst_err", 32'(err_wb_unexp), 32'd0);
    @(negedge clk); reset_n = 1'b1; op_ready = 1'b1;
    drv_wb(1'b1, 5'd11, 32'hB); #1;
    chk("t6_late_wr", 32'(rf_wr_en), 32'd1);
    @(negedge clk); drv_wb(1'b0, 5'd0, 32'h0); #1;
    chk("t6_late_err", 32'(err_wb_unexp), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
